// File: rtl/pkg_amba3.sv
// Shared AMBA 3 AXI types, the SRAM slave FSM state encoding and burst helpers.
package pkg_amba3;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_type_t;

  typedef enum logic [1:0] {
    LOCK_NORMAL    = 2'b00,
    LOCK_EXCLUSIVE = 2'b01,
    LOCK_LOCKED    = 2'b10,
    LOCK_RSVD      = 2'b11
  } lock_type_t;

  typedef logic [3:0] cache_attr_t;
  typedef logic [2:0] prot_attr_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_type_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WDATA = 2'b01,
    ST_WRESP = 2'b10,
    ST_RDATA = 2'b11
  } axi_slave_state_t;

  // Wrapping bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic amba3_wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/amba3_axi_burst_addr.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module amba3_axi_burst_addr
  import pkg_amba3::*;
#(
  parameter int ADDR_BITS = 32
) (
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [3:0]           len,
  input  logic [2:0]           size,
  input  burst_type_t          burst,
  output logic [ADDR_BITS-1:0] next_addr
);

  localparam logic [ADDR_BITS-1:0] ONE = 1;

  logic [ADDR_BITS-1:0] w_step;
  logic [ADDR_BITS-1:0] w_align;
  logic [ADDR_BITS-1:0] w_incr;
  logic [ADDR_BITS-1:0] w_wrap_mask;

  assign w_step      = ONE << size;
  assign w_align     = addr & ~(w_step - ONE);
  assign w_incr      = w_align + w_step;
  // Wrap boundary is (len+1)*step bytes; only the bits below it advance.
  assign w_wrap_mask = (({{(ADDR_BITS-4){1'b0}}, len} + ONE) << size) - ONE;

  always_comb begin
    next_addr = w_incr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
      default:     next_addr = w_incr;
    endcase
  end

endmodule

// File: rtl/amba3_axi_sram_slave.sv
// AXI3 slave backed by a word-addressed internal array; serves one burst at a time.
module amba3_axi_sram_slave
  import pkg_amba3::*;
#(
  parameter int TXID_BITS      = 4,
  parameter int ADDR_BITS      = 32,
  parameter int DATA_BITS      = 32,
  parameter int MEM_WORDS_LOG2 = 10,
  localparam int STRB_BITS     = DATA_BITS / 8,
  localparam int LANE_BITS     = $clog2(STRB_BITS)
) (
  input  logic                 aclk,
  input  logic                 areset,

  input  logic [TXID_BITS-1:0] awid,
  input  logic [ADDR_BITS-1:0] awaddr,
  input  logic [3:0]           awlen,
  input  logic [2:0]           awsize,
  input  burst_type_t          awburst,
  input  lock_type_t           awlock,
  input  cache_attr_t          awcache,
  input  prot_attr_t           awprot,
  input  logic                 awvalid,
  output logic                 awready,

  input  logic [TXID_BITS-1:0] wid,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [STRB_BITS-1:0] wstrb,
  input  logic                 wlast,
  input  logic                 wvalid,
  output logic                 wready,

  output logic [TXID_BITS-1:0] bid,
  output resp_type_t           bresp,
  output logic                 bvalid,
  input  logic                 bready,

  input  logic [TXID_BITS-1:0] arid,
  input  logic [ADDR_BITS-1:0] araddr,
  input  logic [3:0]           arlen,
  input  logic [2:0]           arsize,
  input  burst_type_t          arburst,
  input  lock_type_t           arlock,
  input  cache_attr_t          arcache,
  input  prot_attr_t           arprot,
  input  logic                 arvalid,
  output logic                 arready,

  output logic [TXID_BITS-1:0] rid,
  output logic [DATA_BITS-1:0] rdata,
  output resp_type_t           rresp,
  output logic                 rlast,
  output logic                 rvalid,
  input  logic                 rready
);

  localparam logic [2:0] LANE_SIZE = 3'(LANE_BITS);
  localparam int         MEM_WORDS = 2 ** MEM_WORDS_LOG2;

  axi_slave_state_t      r_state;
  logic [TXID_BITS-1:0]  r_id;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [3:0]            r_len;
  logic [2:0]            r_size;
  burst_type_t           r_burst;
  logic [3:0]            r_beat;
  logic                  r_err;
  logic [DATA_BITS-1:0]  r_rdata;
  logic [DATA_BITS-1:0]  r_mem [MEM_WORDS];

  logic [ADDR_BITS-1:0]      w_next_addr;
  logic                      w_aw_hs;
  logic                      w_ar_hs;
  logic                      w_w_hs;
  logic                      w_last_beat;
  logic                      w_size_err;
  logic                      w_aw_size_err;
  logic                      w_ar_size_err;
  logic                      w_aw_wrap_bad;
  logic                      w_ar_wrap_bad;
  burst_type_t               w_aw_burst;
  burst_type_t               w_ar_burst;
  logic                      w_mem_we;
  logic [MEM_WORDS_LOG2-1:0] w_widx;
  logic [MEM_WORDS_LOG2-1:0] w_ridx;
  logic                      w_rd_load;
  logic                      w_rd_zero;
  logic                      w_unused_ok;

  amba3_axi_burst_addr #(
    .ADDR_BITS (ADDR_BITS)
  ) u_burst_addr (
    .addr      (r_addr),
    .len       (r_len),
    .size      (r_size),
    .burst     (r_burst),
    .next_addr (w_next_addr)
  );

  assign awready = (r_state == ST_IDLE);
  assign arready = (r_state == ST_IDLE) && !awvalid;
  assign wready  = (r_state == ST_WDATA);
  assign bvalid  = (r_state == ST_WRESP);
  assign rvalid  = (r_state == ST_RDATA);
  assign bid     = r_id;
  assign rid     = r_id;
  assign rdata   = r_rdata;
  assign bresp   = (r_state == ST_WRESP && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign rresp   = (r_state == ST_RDATA && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign rlast   = (r_state == ST_RDATA) && w_last_beat;

  assign w_aw_hs     = awvalid && awready;
  assign w_ar_hs     = arvalid && arready;
  assign w_w_hs      = wvalid && wready;
  assign w_last_beat = (r_beat == r_len);
  assign w_size_err  = (r_size > LANE_SIZE);

  assign w_aw_size_err = (awsize > LANE_SIZE);
  assign w_ar_size_err = (arsize > LANE_SIZE);
  assign w_aw_wrap_bad = (awburst == BURST_WRAP) && !amba3_wrap_len_ok(awlen);
  assign w_ar_wrap_bad = (arburst == BURST_WRAP) && !amba3_wrap_len_ok(arlen);
  // Illegal-length wraps run as incrementing bursts.
  assign w_aw_burst    = w_aw_wrap_bad ? BURST_INCR : awburst;
  assign w_ar_burst    = w_ar_wrap_bad ? BURST_INCR : arburst;

  assign w_widx    = r_addr[LANE_BITS +: MEM_WORDS_LOG2];
  assign w_mem_we  = w_w_hs && !w_size_err && !areset;
  assign w_ridx    = (r_state == ST_IDLE) ? araddr[LANE_BITS +: MEM_WORDS_LOG2]
                                          : w_next_addr[LANE_BITS +: MEM_WORDS_LOG2];
  assign w_rd_load = w_ar_hs || (rvalid && rready && !w_last_beat);
  assign w_rd_zero = (r_state == ST_IDLE) ? w_ar_size_err : w_size_err;

  assign w_unused_ok = ^{wid, awlock, awcache, awprot, arlock, arcache, arprot};

  always_ff @(posedge aclk) begin
    if (w_mem_we) begin
      for (int i = 0; i < STRB_BITS; i++) begin
        if (wstrb[i]) r_mem[w_widx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read word is fetched one edge ahead so rdata is valid with rvalid.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rdata <= '0;
    end else if (w_rd_load) begin
      r_rdata <= w_rd_zero ? '0 : r_mem[w_ridx];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= BURST_INCR;
      r_beat  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_aw_hs) begin
            r_id    <= awid;
            r_addr  <= awaddr;
            r_len   <= awlen;
            r_size  <= awsize;
            r_burst <= w_aw_burst;
            r_beat  <= '0;
            r_err   <= w_aw_size_err || w_aw_wrap_bad;
            r_state <= ST_WDATA;
          end else if (w_ar_hs) begin
            r_id    <= arid;
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= w_ar_burst;
            r_beat  <= '0;
            r_err   <= w_ar_size_err || w_ar_wrap_bad;
            r_state <= ST_RDATA;
          end
        end
        ST_WDATA: begin
          if (w_w_hs) begin
            r_addr <= w_next_addr;
            r_beat <= r_beat + 4'd1;
            if (wlast != w_last_beat) r_err <= 1'b1;
            if (w_last_beat) r_state <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (bready) r_state <= ST_IDLE;
        end
        ST_RDATA: begin
          if (rready) begin
            if (w_last_beat) begin
              r_state <= ST_IDLE;
            end else begin
              r_addr <= w_next_addr;
              r_beat <= r_beat + 4'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amba3_axi_sram_slave.sv
// Scoreboard bench for amba3_axi_sram_slave: reference memory model plus queued R expectations.
module tb_amba3_axi_sram_slave;
  import pkg_amba3::*;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  burst_type_t awburst;
  lock_type_t  awlock;
  cache_attr_t awcache;
  prot_attr_t  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  resp_type_t  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  burst_type_t arburst;
  lock_type_t  arlock;
  cache_attr_t arcache;
  prot_attr_t  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  resp_type_t  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mdl [1024];
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] exp_q [$];

  always #5 aclk = ~aclk;

  amba3_axi_sram_slave dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // AXI beat address from first principles: aligned start plus n steps, wrapped into the boundary window.
  function automatic int unsigned beat_addr(input int unsigned a, input int n, input int len,
                                            input int size, input burst_type_t b);
    int unsigned bytes, total, aligned, lower, r;
    bytes   = 1 << size;
    total   = bytes * (len + 1);
    aligned = (a / bytes) * bytes;
    lower   = (a / total) * total;
    if (b == BURST_FIXED) begin
      r = a;
    end else if (b == BURST_WRAP && (len inside {1, 3, 7, 15})) begin
      r = aligned + n * bytes;
      if (r >= lower + total) r = r - total;
    end else begin
      r = (n == 0) ? a : aligned + n * bytes;
    end
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, awready, 1);
    check({tag, "_wready"},  wready,  0);
    check({tag, "_bvalid"},  bvalid,  0);
    check({tag, "_rvalid"},  rvalid,  0);
    check({tag, "_rlast"},   rlast,   0);
    check({tag, "_bid"},     bid,     0);
    check({tag, "_rid"},     rid,     0);
    check({tag, "_rdata"},   rdata,   0);
    check({tag, "_bresp"},   bresp,   RESP_OKAY);
    check({tag, "_rresp"},   rresp,   RESP_OKAY);
  endtask

  // Entered between a negedge and the next posedge; returns likewise.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input burst_type_t burst, input int wlast_at,
                          input resp_type_t exp_resp, input bit ar_blocked, input lock_type_t lock);
    bit ok;
    int unsigned a;
    int idx;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awlock = lock;
    awvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (ar_blocked) check("ar_blocked_aw", arready, 0);
      if (awready) begin ok = 1'b1; break; end
      @(negedge aclk);
    end
    if (!ok) begin
      check("aw_timeout", 0, 1);
      awvalid = 1'b0;
      return;
    end
    @(posedge aclk); @(negedge aclk);
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wid = id; wdata = wbuf[b]; wstrb = sbuf[b];
      wlast = (wlast_at < 0) ? (b == int'(len)) : (b == wlast_at);
      wvalid = 1'b1;
      #1;
      check("wready", wready, 1);
      if (ar_blocked) check("ar_blocked_w", arready, 0);
      if (!wready) begin wvalid = 1'b0; return; end
      @(posedge aclk);
      if (size <= 3'd2) begin
        a = beat_addr(addr, b, int'(len), int'(size), burst);
        idx = int'((a >> 2) & 32'h3FF);
        for (int l = 0; l < 4; l++) if (sbuf[b][l]) mdl[idx][l*8 +: 8] = wbuf[b][l*8 +: 8];
      end
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    #1;
    check("bvalid", bvalid, 1);
    check("bid", bid, id);
    check("bresp", bresp, exp_resp);
    if (ar_blocked) check("ar_blocked_b", arready, 0);
    $display("txn write id=%0d addr=0x%0h len=%0d size=%0d burst=%0d bresp=%0d", id, addr, len, size, burst, bresp);
    bready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    bready = 1'b0;
    #1;
    check("bvalid_drop", bvalid, 0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input burst_type_t burst,
                         input resp_type_t exp_resp, input bit stall);
    bit ok;
    int unsigned a;
    logic [31:0] e;
    for (int n = 0; n <= int'(len); n++) begin
      a = beat_addr(addr, n, int'(len), int'(size), burst);
      exp_q.push_back((size > 3'd2) ? 32'h0 : mdl[(a >> 2) & 32'h3FF]);
    end
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (arready) begin ok = 1'b1; break; end
      @(negedge aclk);
    end
    if (!ok) begin
      check("ar_timeout", 0, 1);
      arvalid = 1'b0;
      exp_q.delete();
      return;
    end
    @(posedge aclk); @(negedge aclk);
    arvalid = 1'b0;
    rready = 1'b1;
    for (int n = 0; n <= int'(len); n++) begin
      #1;
      check("rvalid", rvalid, 1);
      if (!rvalid) begin rready = 1'b0; exp_q.delete(); return; end
      e = exp_q.pop_front();
      check("rdata", rdata, e);
      check("rid", rid, id);
      check("rresp", rresp, exp_resp);
      check("rlast", rlast, (n == int'(len)));
      if (stall && n == 1) begin
        rready = 1'b0;
        @(posedge aclk); @(negedge aclk);
        #1;
        check("stall_rvalid", rvalid, 1);
        check("stall_rdata", rdata, e);
        check("stall_rlast", rlast, (n == int'(len)));
        rready = 1'b1;
      end
      @(posedge aclk); @(negedge aclk);
    end
    rready = 1'b0;
    #1;
    check("rvalid_drop", rvalid, 0);
    $display("txn read  id=%0d addr=0x%0h len=%0d size=%0d burst=%0d rresp=%0d", id, addr, len, size, burst, exp_resp);
  endtask

  initial begin
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = BURST_INCR; awlock = LOCK_NORMAL;
    awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = BURST_INCR; arlock = LOCK_NORMAL;
    arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check_reset_outputs("reset");
    check("reset_arready", arready, 1);

    // INCR burst, exclusive lock still answers OKAY
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + i; sbuf[i] = 4'hF; end
    do_write(4'd3, 32'h100, 4'd3, 3'd2, BURST_INCR, -1, RESP_OKAY, 1'b0, LOCK_EXCLUSIVE);
    do_read(4'd5, 32'h100, 4'd3, 3'd2, BURST_INCR, RESP_OKAY, 1'b0);
    do_read(4'd6, 32'h100, 4'd3, 3'd2, BURST_INCR, RESP_OKAY, 1'b1);

    // WRAP from 0x38: 0x38, 0x3C, 0x30, 0x34
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hC0DE_0000 + i; sbuf[i] = 4'hF; end
    do_write(4'd1, 32'h38, 4'd3, 3'd2, BURST_WRAP, -1, RESP_OKAY, 1'b0, LOCK_NORMAL);
    do_read(4'd1, 32'h38, 4'd3, 3'd2, BURST_WRAP, RESP_OKAY, 1'b0);
    do_read(4'd2, 32'h30, 4'd3, 3'd2, BURST_INCR, RESP_OKAY, 1'b0);

    // Byte strobes
    wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
    do_write(4'd4, 32'h40, 4'd0, 3'd2, BURST_INCR, -1, RESP_OKAY, 1'b0, LOCK_NORMAL);
    wbuf[0] = 32'h1122_3344; sbuf[0] = 4'b0101;
    do_write(4'd4, 32'h40, 4'd0, 3'd2, BURST_INCR, -1, RESP_OKAY, 1'b0, LOCK_NORMAL);
    do_read(4'd4, 32'h40, 4'd0, 3'd2, BURST_INCR, RESP_OKAY, 1'b0);

    // Simultaneous AW and AR: write wins, read waits for the B handshake
    arid = 4'd9; araddr = 32'h100; arlen = 4'd3; arsize = 3'd2; arburst = BURST_INCR; arvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin wbuf[i] = 32'h5150_0000 + i; sbuf[i] = 4'hF; end
    do_write(4'd8, 32'h140, 4'd1, 3'd2, BURST_INCR, -1, RESP_OKAY, 1'b1, LOCK_NORMAL);
    check("ar_after_b", arready, 1);
    do_read(4'd9, 32'h100, 4'd3, 3'd2, BURST_INCR, RESP_OKAY, 1'b0);

    // Oversized beat: SLVERR, array untouched, oversized read returns 0
    wbuf[0] = 32'h1234_5678; sbuf[0] = 4'hF;
    do_write(4'd2, 32'h200, 4'd0, 3'd2, BURST_INCR, -1, RESP_OKAY, 1'b0, LOCK_NORMAL);
    wbuf[0] = 32'hDEAD_BEEF; sbuf[0] = 4'hF;
    do_write(4'd2, 32'h200, 4'd0, 3'd3, BURST_INCR, -1, RESP_SLVERR, 1'b0, LOCK_NORMAL);
    do_read(4'd2, 32'h200, 4'd0, 3'd2, BURST_INCR, RESP_OKAY, 1'b0);
    do_read(4'd2, 32'h200, 4'd0, 3'd3, BURST_INCR, RESP_SLVERR, 1'b0);

    // WRAP with 3 beats runs as INCR and reports SLVERR
    for (int i = 0; i < 3; i++) begin wbuf[i] = 32'h6600_0000 + i; sbuf[i] = 4'hF; end
    do_write(4'd7, 32'h64, 4'd2, 3'd2, BURST_WRAP, -1, RESP_SLVERR, 1'b0, LOCK_NORMAL);
    do_read(4'd7, 32'h64, 4'd2, 3'd2, BURST_INCR, RESP_OKAY, 1'b0);
    do_read(4'd7, 32'h64, 4'd2, 3'd2, BURST_WRAP, RESP_SLVERR, 1'b0);

    // Early wlast on beat 0 of two
    for (int i = 0; i < 2; i++) begin wbuf[i] = 32'h8800_0000 + i; sbuf[i] = 4'hF; end
    do_write(4'd10, 32'h80, 4'd1, 3'd2, BURST_INCR, 0, RESP_SLVERR, 1'b0, LOCK_NORMAL);
    do_read(4'd10, 32'h80, 4'd1, 3'd2, BURST_INCR, RESP_OKAY, 1'b0);

    // FIXED burst overwrites one word
    for (int i = 0; i < 3; i++) begin wbuf[i] = 32'h9900_0000 + i; sbuf[i] = 4'hF; end
    do_write(4'd11, 32'h90, 4'd2, 3'd2, BURST_FIXED, -1, RESP_OKAY, 1'b0, LOCK_NORMAL);
    do_read(4'd11, 32'h90, 4'd1, 3'd2, BURST_FIXED, RESP_OKAY, 1'b0);

    // Reset during beat 1 of a 4-beat write
    awid = 4'd12; awaddr = 32'h300; awlen = 4'd3; awsize = 3'd2; awburst = BURST_INCR; awvalid = 1'b1;
    #1;
    check("rst_awready", awready, 1);
    @(posedge aclk); @(negedge aclk);
    awvalid = 1'b0;
    wdata = 32'h3300_0000; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    #1;
    check("rst_wready", wready, 1);
    @(posedge aclk);
    if (wready) mdl[32'h300 >> 2] = 32'h3300_0000;
    @(negedge aclk);
    wdata = 32'h3300_0001; areset = 1'b1;
    @(posedge aclk); @(negedge aclk);
    areset = 1'b0; wvalid = 1'b0;
    #1;
    check_reset_outputs("midrst");
    $display("txn reset mid-write addr=0x300");
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk); #1;
      check("midrst_no_b", bvalid, 0);
    end
    do_read(4'd12, 32'h300, 4'd0, 3'd2, BURST_INCR, RESP_OKAY, 1'b0);
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h4400_0000 + i; sbuf[i] = 4'hF; end
    do_write(4'd13, 32'h310, 4'd3, 3'd2, BURST_INCR, -1, RESP_OKAY, 1'b0, LOCK_NORMAL);
    do_read(4'd13, 32'h310, 4'd3, 3'd2, BURST_INCR, RESP_OKAY, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/amba3_axi_sram_slave.md
# amba3_axi_sram_slave

Synthesizable AMBA 3 AXI slave that terminates the `amba3_axi_if` bus on its slave side and backs it with an internal word-addressed memory array. It is the downstream consumer of the interface's master traffic and provides a real RTL target for the master and monitor tasks. One burst is in service at a time, write or read, with one data beat per cycle throughput.

## Interface
Parameters:
- `TXID_BITS`, default 4: transaction ID width.
- `ADDR_BITS`, default 32: byte address width.
- `DATA_BITS`, default 32: data width, a multiple of 8. `STRB_BITS = DATA_BITS/8`; `LANE_BITS = $clog2(STRB_BITS)`.
- `MEM_WORDS_LOG2`, default 10: the array holds 2^MEM_WORDS_LOG2 words of DATA_BITS.

Ports:
- `aclk`, input, 1: the single clock.
- `areset`, input, 1: synchronous, active-high reset.
- `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awlock`, `awcache`, `awprot`, `awvalid`: inputs, widths TXID_BITS/ADDR_BITS/4/3/burst_type_t/lock_type_t/cache_attr_t/prot_attr_t/1. Write address channel.
- `awready`, output, 1.
- `wid`, `wdata`, `wstrb`, `wlast`, `wvalid`: inputs, widths TXID_BITS/DATA_BITS/STRB_BITS/1/1. Write data channel.
- `wready`, output, 1.
- `bid`, `bresp`, `bvalid`: outputs, widths TXID_BITS/resp_type_t/1. `bready`, input, 1.
- `arid`, `araddr`, `arlen`, `arsize`, `arburst`, `arlock`, `arcache`, `arprot`, `arvalid`: inputs, widths as for AW.
- `arready`, output, 1.
- `rid`, `rdata`, `rresp`, `rlast`, `rvalid`: outputs, widths TXID_BITS/DATA_BITS/resp_type_t/1/1. `rready`, input, 1.

## Operation
- FSM states: IDLE, WDATA, WRESP, RDATA. Reset puts the FSM in IDLE.
- Ready signals (combinational from state):
  - `awready = (state==IDLE)`.
  - `arready = (state==IDLE) && !awvalid`. Writes win simultaneous requests.
- IDLE:
  - On AW handshake, latch id/addr/len/size/burst, clear the beat counter, clear the error flag, and go to WDATA.
  - On AR handshake, latch the same fields, load `rdata` from mem[araddr word index], and go to RDATA.
- Word index is `addr[LANE_BITS +: MEM_WORDS_LOG2]`. Higher address bits alias, so out-of-range addresses wrap.
- Error flag is set if any of these hold:
  - `size > LANE_BITS`. In this case nothing is written to the array, and reads return 0.
  - WRAP burst with len not in {1,3,7,15}. Such a burst is executed as INCR.
  - On writes, `wlast != (beat==len)` on any beat.
- WDATA:
  - `wready=1`.
  - Each W handshake writes the byte lanes enabled by `wstrb` to the current word, then advances the address and beat counter.
  - The beat with `beat==len` moves the FSM to WRESP. `wlast` does not terminate the burst.
  - `wid` is ignored.
- WRESP: `bvalid=1`, `bid`=latched id, `bresp` is SLVERR if the error flag is set, else OKAY. On `bready`, return to IDLE.
- RDATA:
  - `rvalid=1`, `rid`=latched id, `rlast=(beat==len)`, `rresp` is SLVERR or OKAY by the error flag.
  - On `rready` with not-last: advance the address and counter, and reload `rdata` from the next word in the same edge.
  - On `rready` with last: return to IDLE.
- Next-address rules, with `step = 1<<size`:
  - FIXED: address unchanged.
  - INCR: `addr + step`, aligned down to step.
  - WRAP: boundary is `(len+1)*step`. The low bits wrap modulo the boundary; the high bits are held.
- Exclusive `*lock` gets OKAY, meaning exclusive failed. `*cache` and `*prot` are ignored.

## Timing
- Reset values: `awready=1`, `arready=1` (state IDLE, gated by `awvalid`), `wready=0`, `bvalid=0`, `rvalid=0`, `rlast=0`, `bid=0`, `rid=0`, `rdata=0`, `bresp=OKAY`, `rresp=OKAY`. Memory contents are not reset.
- Reset mid-burst: the FSM is in IDLE on the next edge. Beats already written remain in the array; no B or R response is issued for the aborted burst.
- `wready` rises the cycle after the AW handshake. `bvalid` rises the cycle after the last W handshake.
- `rvalid` rises the cycle after the AR handshake. Beats are back-to-back while `rready` is held.
- A new AW/AR is accepted no earlier than the cycle after the B or final R handshake.
- `rdata`, `rid`, `rresp`, `rlast`, `bid`, `bresp` are stable while their valid is high and ready is low.

## Structure
- Types `burst_type_t`, `lock_type_t`, `cache_attr_t`, `prot_attr_t`, `resp_type_t` come from `pkg_amba3`.
- Add to `pkg_amba3`: the FSM state enum and the function `amba3_wrap_len_ok(len)`.
- One combinational sub-module, `amba3_axi_burst_addr` (inputs addr, len, size, burst; output next_addr). It is shared by the write and read paths.

## Test plan
- AW INCR addr 0x100, len 3, size 2, data 0xA0..0xA3, full strobes; then AR of the same burst. Required: bresp OKAY, R beats 0xA0..0xA3, `rlast` only on beat 3, no bubbles with `rready` held.
- WRAP addr 0x38, len 3, size 2. Required: beat addresses 0x38, 0x3C, 0x30, 0x34; readback matches.
- Write 0xFFFFFFFF then wstrb 4'b0101 with data 0x11223344 to 0x40. Required: read returns 0xFF22FF44.
- Simultaneous `awvalid` and `arvalid` in IDLE. Required: AW accepted first, `arready=0` until the B handshake completes, then the read is served.
- Each of: size 3 on a 32-bit bus, WRAP with len 2, `wlast` asserted on beat 0 of len 1. Required: SLVERR; for the size error, the array is unchanged.
- `areset` pulsed during WDATA beat 1 of 4. Required: next cycle all outputs at reset values, no `bvalid`; a following burst completes normally.
